// File: rtl/dump_pkg.sv
// Shared definitions for the debug dump unit: beat tags, FSM states and counter count.
package dump_pkg;

    localparam logic [1:0] TAG_CNT = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;

    localparam int NUM_CNT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CNT  = 2'd1,
        ST_REG  = 2'd2,
        ST_MEM  = 2'd3
    } state_e;

endpackage

// File: rtl/debug_dump_unit_perf_counters.sv
// Free-running cycle/stall/flush counters with snapshot registers for the dump.
module perf_counters #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic              snap_i,
    output logic [DATA_W-1:0] cycle_o,
    output logic [DATA_W-1:0] stall_o,
    output logic [DATA_W-1:0] flush_o,
    output logic [DATA_W-1:0] snap_stall_o,
    output logic [DATA_W-1:0] snap_flush_o
);

    logic [DATA_W-1:0] cycle_q, stall_q, flush_q;
    logic [DATA_W-1:0] snap_stall_q, snap_flush_q;

    // Only stall/flush need snapshots: the cycle beat is loaded from the live value at the request edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q      <= '0;
            stall_q      <= '0;
            flush_q      <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
        end else begin
            if (start_i) begin
                cycle_q <= cycle_q + DATA_W'(1);
                if (stall_i && !branch_i) stall_q <= stall_q + DATA_W'(1);
                if (flush_i)              flush_q <= flush_q + DATA_W'(1);
            end
            if (snap_i) begin
                snap_stall_q <= stall_q;
                snap_flush_q <= flush_q;
            end
        end
    end

    assign cycle_o      = cycle_q;
    assign stall_o      = stall_q;
    assign flush_o      = flush_q;
    assign snap_stall_o = snap_stall_q;
    assign snap_flush_o = snap_flush_q;

endmodule

// File: rtl/debug_dump_unit.sv
// Streams a snapshot of perf counters, register file and low data memory over valid/ready.
// state   | meaning
// ST_IDLE | no dump; dump_req_i sampled each edge
// ST_CNT  | output register holds a counter beat
// ST_REG  | output register holds a register-file beat
// ST_MEM  | output register holds a data-memory beat
module debug_dump_unit
    import dump_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_DMEM = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic              dump_req_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] dmem_addr_o,
    input  logic [DATA_W-1:0] dmem_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [1:0]        dump_tag_o,
    output logic [7:0]        dump_index_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] cycle_cnt_o,
    output logic [DATA_W-1:0] stall_cnt_o,
    output logic [DATA_W-1:0] flush_cnt_o
);

    state_e            state_q, state_d, nxt_state;
    logic [7:0]        idx_q, idx_d, nxt_idx;
    logic              nxt_done, advance, snap;
    logic              valid_q, valid_d, last_q, last_d;
    logic [1:0]        tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d, payload;
    logic [DATA_W-1:0] snap_stall, snap_flush;

    assign snap = (state_q == ST_IDLE) && dump_req_i;

    perf_counters #(.DATA_W(DATA_W)) u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .flush_i      (flush_i),
        .snap_i       (snap),
        .cycle_o      (cycle_cnt_o),
        .stall_o      (stall_cnt_o),
        .flush_o      (flush_cnt_o),
        .snap_stall_o (snap_stall),
        .snap_flush_o (snap_flush)
    );

    // (state_q, idx_q) names the beat held in the output register; this derives the following one.
    always_comb begin
        nxt_state = state_q;
        nxt_idx   = idx_q + 8'd1;
        nxt_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                nxt_state = ST_CNT;
                nxt_idx   = 8'd0;
            end
            ST_CNT: if (idx_q == 8'(NUM_CNT - 1)) begin
                nxt_state = ST_REG;
                nxt_idx   = 8'd0;
            end
            ST_REG: if (idx_q == 8'(NUM_REGS - 1)) begin
                nxt_state = ST_MEM;
                nxt_idx   = 8'd0;
            end
            ST_MEM: if (idx_q == 8'(NUM_DMEM - 1)) begin
                nxt_state = ST_IDLE;
                nxt_idx   = 8'd0;
                nxt_done  = 1'b1;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_idx   = 8'd0;
            end
        endcase
    end

    assign reg_addr_o  = (nxt_state == ST_REG) ? nxt_idx[4:0] : 5'd0;
    assign dmem_addr_o = (nxt_state == ST_MEM) ? DATA_W'({nxt_idx, 2'b00}) : '0;

    always_comb begin
        payload = '0;
        case (nxt_state)
            ST_CNT: begin
                if (nxt_idx == 8'd0)      payload = cycle_cnt_o;
                else if (nxt_idx == 8'd1) payload = snap_stall;
                else                      payload = snap_flush;
            end
            ST_REG:  payload = reg_data_i;
            ST_MEM:  payload = dmem_data_i;
            default: payload = '0;
        endcase
    end

    assign advance = (state_q == ST_IDLE) ? dump_req_i : (valid_q && dump_ready_i);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        last_d  = last_q;
        if (advance) begin
            state_d = nxt_state;
            idx_d   = nxt_idx;
            valid_d = !nxt_done;
            data_d  = payload;
            last_d  = (nxt_state == ST_MEM) && (nxt_idx == 8'(NUM_DMEM - 1));
            case (nxt_state)
                ST_REG:  tag_d = TAG_REG;
                ST_MEM:  tag_d = TAG_MEM;
                default: tag_d = TAG_CNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign dump_valid_o = valid_q;
    assign dump_tag_o   = tag_q;
    assign dump_index_o = idx_q;
    assign dump_data_o  = data_q;
    assign dump_last_o  = last_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed bench for debug_dump_unit with register-file and data-memory models.
module tb_debug_dump_unit;

    localparam int NBEATS = 43;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0;
    logic        req = 1'b0, ready = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, dmem_addr, dmem_data;
    logic        valid, last, busy;
    logic [1:0]  tag;
    logic [7:0]  idx;
    logic [31:0] data, cyc_cnt, stl_cnt, fls_cnt;

    logic [31:0] regs_m [32];
    logic [31:0] dmem_m [8];

    logic [1:0]  bt_tag   [64];
    logic [7:0]  bt_idx   [64];
    logic [31:0] bt_data  [64];
    logic        bt_last  [64];
    logic [4:0]  bt_raddr [64];
    logic [31:0] bt_daddr [64];

    int tests = 0;
    int fails = 0;

    assign reg_data  = regs_m[reg_addr];
    assign dmem_data = (dmem_addr < 32'd32) ? dmem_m[dmem_addr[4:2]] : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    debug_dump_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
        .flush_i(flush), .dump_req_i(req), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
        .dmem_addr_o(dmem_addr), .dmem_data_i(dmem_data), .dump_valid_o(valid),
        .dump_ready_i(ready), .dump_tag_o(tag), .dump_index_o(idx), .dump_data_o(data),
        .dump_last_o(last), .busy_o(busy), .cycle_cnt_o(cyc_cnt), .stall_cnt_o(stl_cnt),
        .flush_cnt_o(fls_cnt)
    );

    function automatic logic [1:0] exp_tag(input int k);
        return (k < 3) ? 2'd0 : (k < 35) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] exp_idx(input int k);
        return (k < 3) ? 8'(k) : (k < 35) ? 8'(k - 3) : 8'(k - 35);
    endfunction

    task automatic do_reset(input logic st);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = st;
    endtask

    // Call at a negedge; records every transferred beat, returns at the negedge where the last beat is accepted.
    task automatic collect_dump(input bit rnd, output int n, output int hold_err, output bit tmo);
        logic       prev_stalled;
        logic       rdy;
        logic [1:0] p_tag;
        logic [7:0] p_idx;
        logic [31:0] p_data;
        logic       p_last;
        n = 0; hold_err = 0; tmo = 1'b1; prev_stalled = 1'b0;
        p_tag = '0; p_idx = '0; p_data = '0; p_last = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (prev_stalled && (valid !== 1'b1 || tag !== p_tag || idx !== p_idx ||
                                 data !== p_data || last !== p_last))
                hold_err++;
            rdy = (rnd && valid) ? 1'($urandom_range(0, 1)) : 1'b1;
            ready = rdy;
            if (valid && rdy && n < 64) begin
                bt_tag[n] = tag; bt_idx[n] = idx; bt_data[n] = data; bt_last[n] = last;
                bt_raddr[n] = reg_addr; bt_daddr[n] = dmem_addr;
                n++;
                if (last) begin
                    tmo = 1'b0;
                    break;
                end
            end
            prev_stalled = valid && !rdy;
            p_tag = tag; p_idx = idx; p_data = data; p_last = last;
            @(negedge clk);
        end
        ready = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || tag !== 2'd0 || idx !== 8'd0 ||
            data !== 32'd0 || reg_addr !== 5'd0 || dmem_addr !== 32'd0 ||
            cyc_cnt !== 32'd0 || stl_cnt !== 32'd0 || fls_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%0b busy=%0b tag=%0d idx=%0d data=%0h cyc=%0d want all zero",
                     valid, busy, tag, idx, data, cyc_cnt);
        end
    endtask

    task automatic test_basic_dump;
        int n, herr; bit tmo; int bad;
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        collect_dump(1'b0, n, herr, tmo);
        tests++;
        if (tmo || n !== NBEATS) begin
            fails++; $display("FAIL basic_count: beats=%0d timeout=%0b want %0d", n, tmo, NBEATS);
        end
        tests++;
        if (bt_data[0] !== 32'd10 || bt_data[1] !== 32'd0 || bt_data[2] !== 32'd0) begin
            fails++; $display("FAIL basic_counters: got %0d %0d %0d want 10 0 0", bt_data[0], bt_data[1], bt_data[2]);
        end
        bad = 0;
        for (int k = 0; k < n; k++)
            if (bt_tag[k] !== exp_tag(k) || bt_idx[k] !== exp_idx(k) || bt_last[k] !== (k == NBEATS - 1))
                bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL basic_order: %0d beats with wrong tag/index/last, want 0", bad);
        end
        @(negedge clk);
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_end: valid=%0b busy=%0b want 0 0", valid, busy);
        end
    endtask

    task automatic test_data_ports;
        int n, herr; bit tmo; int bad_r, bad_m, bad_a;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        collect_dump(1'b0, n, herr, tmo);
        @(negedge clk);
        tests++;
        if (tmo || n !== NBEATS) begin
            fails++; $display("FAIL data_count: beats=%0d timeout=%0b want %0d", n, tmo, NBEATS);
            return;
        end
        tests++;
        if (bt_tag[27] !== 2'd1 || bt_idx[27] !== 8'd24 || bt_data[27] !== 32'hFFFF_FFE8) begin
            fails++; $display("FAIL data_reg24: tag=%0d idx=%0d data=%h want 1 24 ffffffe8",
                              bt_tag[27], bt_idx[27], bt_data[27]);
        end
        tests++;
        if (bt_data[35] !== 32'd5 || bt_data[36] !== 32'd6 || bt_data[37] !== 32'd10 ||
            bt_data[38] !== 32'd18 || bt_data[39] !== 32'd29) begin
            fails++; $display("FAIL data_mem0_4: got %0d %0d %0d %0d %0d want 5 6 10 18 29",
                              bt_data[35], bt_data[36], bt_data[37], bt_data[38], bt_data[39]);
        end
        bad_r = 0; bad_m = 0; bad_a = 0;
        for (int k = 3; k < 35; k++) if (bt_data[k] !== regs_m[k - 3]) bad_r++;
        for (int k = 35; k < 43; k++) if (bt_data[k] !== dmem_m[k - 35]) bad_m++;
        for (int k = 2; k < 34; k++) if (bt_raddr[k] !== 5'(k - 2)) bad_a++;
        for (int k = 34; k < 42; k++) if (bt_daddr[k] !== 32'(4 * (k - 34))) bad_a++;
        tests++;
        if (bad_r != 0 || bad_m != 0) begin
            fails++; $display("FAIL data_payload: reg errs=%0d mem errs=%0d want 0 0", bad_r, bad_m);
        end
        tests++;
        if (bad_a != 0) begin
            fails++; $display("FAIL data_addr: %0d wrong read addresses, want 0 (dmem 0x00..0x1C)", bad_a);
        end
    endtask

    task automatic test_counters;
        int n, herr; bit tmo;
        do_reset(1'b1);
        stall = 1'b1;
        repeat (4) @(negedge clk);
        branch = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b0; branch = 1'b0; flush = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        tests++;
        if (cyc_cnt !== 32'd10 || stl_cnt !== 32'd4 || fls_cnt !== 32'd3) begin
            fails++; $display("FAIL cnt_live: cyc=%0d stall=%0d flush=%0d want 10 4 3", cyc_cnt, stl_cnt, fls_cnt);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        collect_dump(1'b0, n, herr, tmo);
        @(negedge clk);
        tests++;
        if (tmo || bt_data[0] !== 32'd10 || bt_data[1] !== 32'd4 || bt_data[2] !== 32'd3) begin
            fails++; $display("FAIL cnt_dump: got %0d %0d %0d timeout=%0b want 10 4 3",
                              bt_data[0], bt_data[1], bt_data[2], tmo);
        end
    endtask

    task automatic test_backpressure;
        int n, herr; bit tmo; int bad;
        do_reset(1'b0);
        stall = 1'b1; flush = 1'b1;
        repeat (5) @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        tests++;
        if (cyc_cnt !== 32'd0 || stl_cnt !== 32'd0 || fls_cnt !== 32'd0) begin
            fails++; $display("FAIL bp_gate: cyc=%0d stall=%0d flush=%0d want 0 0 0", cyc_cnt, stl_cnt, fls_cnt);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        collect_dump(1'b1, n, herr, tmo);
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < n; k++) begin
            if (bt_tag[k] !== exp_tag(k) || bt_idx[k] !== exp_idx(k) || bt_last[k] !== (k == NBEATS - 1))
                bad++;
            if (k < 3 && bt_data[k] !== 32'd0) bad++;
            if (k >= 3 && k < 35 && bt_data[k] !== regs_m[k - 3]) bad++;
            if (k >= 35 && k < 43 && bt_data[k] !== dmem_m[k - 35]) bad++;
        end
        tests++;
        if (tmo || n !== NBEATS || bad != 0) begin
            fails++; $display("FAIL bp_stream: beats=%0d errs=%0d timeout=%0b want %0d 0 0", n, bad, tmo, NBEATS);
        end
        tests++;
        if (herr != 0) begin
            fails++; $display("FAIL bp_hold: %0d stalled cycles changed payload, want 0", herr);
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2, herr; bit tmo1, tmo2; logic [31:0] c1; int quiet;
        start = 1'b1;
        req = 1'b1;
        @(negedge clk);
        collect_dump(1'b0, n1, herr, tmo1);
        c1 = bt_data[0];
        @(negedge clk);
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_gap: valid=%0b busy=%0b want 0 0", valid, busy);
        end
        @(negedge clk);
        tests++;
        if (valid !== 1'b1 || tag !== 2'd0 || idx !== 8'd0) begin
            fails++; $display("FAIL b2b_restart: valid=%0b tag=%0d idx=%0d want 1 0 0", valid, tag, idx);
        end
        req = 1'b0;
        collect_dump(1'b0, n2, herr, tmo2);
        tests++;
        if (tmo1 || tmo2 || n1 !== NBEATS || n2 !== NBEATS || bt_last[NBEATS - 1] !== 1'b1) begin
            fails++; $display("FAIL b2b_count: beats=%0d,%0d want %0d,%0d", n1, n2, NBEATS, NBEATS);
        end
        tests++;
        if (bt_data[0] - c1 !== 32'd44) begin
            fails++; $display("FAIL b2b_cycle_gap: got %0d want 44", bt_data[0] - c1);
        end
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) quiet++;
        end
        tests++;
        if (quiet != 0) begin
            fails++; $display("FAIL b2b_third: %0d cycles busy after second dump, want 0", quiet);
        end
    endtask

    task automatic test_reset_mid_dump;
        int n, herr, xfers; bit tmo;
        start = 1'b1;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        ready = 1'b1;
        xfers = 0;
        while (xfers < 20 && valid === 1'b1) begin
            @(negedge clk);
            xfers++;
        end
        tests++;
        if (xfers !== 20 || idx !== 8'd17 || tag !== 2'd1) begin
            fails++; $display("FAIL rstmid_pos: xfers=%0d tag=%0d idx=%0d want 20 1 17", xfers, tag, idx);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || cyc_cnt !== 32'd0 || stl_cnt !== 32'd0 || fls_cnt !== 32'd0) begin
            fails++; $display("FAIL rstmid_async: valid=%0b busy=%0b cyc=%0d want 0 0 0", valid, busy, cyc_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        collect_dump(1'b0, n, herr, tmo);
        @(negedge clk);
        tests++;
        if (tmo || n !== NBEATS || bt_data[0] !== 32'd3 || bt_data[1] !== 32'd0 || bt_tag[3] !== 2'd1 ||
            bt_idx[3] !== 8'd0 || bt_data[42] !== dmem_m[7]) begin
            fails++; $display("FAIL rstmid_redump: beats=%0d cyc=%0d want %0d 3", n, bt_data[0], NBEATS);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0000_0100 + 32'(i);
        regs_m[24] = 32'hFFFF_FFE8;
        dmem_m[0] = 32'd5;  dmem_m[1] = 32'd6;  dmem_m[2] = 32'd10; dmem_m[3] = 32'd18;
        dmem_m[4] = 32'd29; dmem_m[5] = 32'h40; dmem_m[6] = 32'h41; dmem_m[7] = 32'h42;
        test_reset;
        test_basic_dump;
        test_data_ports;
        test_counters;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_dump;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
